spi_mem_loader: RTL and testbench
=================================

SPI_MEM_LOADER -- requirements
Module: spi_mem_loader

Interface
REQ-001 SHALL have parameter ADDR_W, default 7, memory address width.
REQ-002 SHALL have parameter DATA_W, default 8, memory data width and SPI byte length.
REQ-003 SHALL have one clock and an asynchronous active-low reset: port `clk`, input, 1 bit, system clock; port `rst_n`, input, 1 bit, asynchronous active-low reset.
REQ-004 `sclk` SHALL be an input of 1 bit carrying the SPI serial clock (mode 0), asynchronous to `clk`.
REQ-005 `cs_n` SHALL be an input of 1 bit carrying the SPI chip select, active low.
REQ-006 `mosi` SHALL be an input of 1 bit carrying SPI data in, MSB first.
REQ-007 `miso` SHALL be an output of 1 bit carrying SPI data out, MSB first.
REQ-008 `mem_addr` SHALL be an output of ADDR_W bits carrying the memory address.
REQ-009 `mem_wdata` SHALL be an output of DATA_W bits carrying the memory write data.
REQ-010 `mem_wr` SHALL be an output of 1 bit carrying a one-`clk` write strobe.
REQ-011 `mem_rdata` SHALL be an input of DATA_W bits carrying memory read data, valid 1 `clk` after `mem_addr` is stable.
REQ-012 `active` SHALL be an output of 1 bit that is high while a transaction is open.

Function
REQ-013 `sclk`, `cs_n` and `mosi` SHALL each pass a 2-flop synchronizer; `sclk` edges SHALL be detected in the `clk` domain.
REQ-014 Legal input timing SHALL be: `sclk` high and low phases each of at least 4 `clk` periods.
REQ-015 `mosi` SHALL be sampled on each detected `sclk` rising edge while `cs_n` is low.
REQ-016 FSM states SHALL be IDLE, CMD and DATA; the falling edge of `cs_n` SHALL move the FSM from IDLE to CMD and clear the bit counter.
REQ-017 The first byte of a transaction SHALL be the command: bit 7 = 1 means write, bit 7 = 0 means read, bits 6:0 = start address.
REQ-018 On the 8th rising edge of the command byte, `mem_addr` SHALL load the address and the FSM SHALL move to DATA.
REQ-019 Write, each further full byte: `mem_wdata` SHALL take the byte and `mem_wr` SHALL pulse high for exactly 1 `clk`, 1 `clk` after the 8th rising edge, with `mem_addr` held stable during the pulse.
REQ-020 Read: 2 `clk` after `mem_addr` is updated, the transmit register SHALL load `mem_rdata`, and `miso` SHALL present bit 7 of that value immediately.
REQ-021 Read: `miso` SHALL shift on each detected `sclk` falling edge, except the first falling edge after a byte boundary.
REQ-022 In the read direction, `mosi` data bytes SHALL be ignored; in the write direction, `miso` SHALL be 0.
REQ-023 Deasserting `cs_n` mid-byte SHALL discard the partial byte, produce no `mem_wr`, and return the FSM to IDLE within 3 `clk`.
REQ-024 Deasserting `cs_n` exactly at a byte boundary SHALL still complete that byte's write.
REQ-025 `active` SHALL equal (state != IDLE).
REQ-026 `sclk` edges while `cs_n` is high SHALL be ignored.

Reset
REQ-027 While `rst_n` is low, `mem_addr`=0, `mem_wdata`=0, `mem_wr`=0, `miso`=0 and `active`=0, the FSM SHALL be in IDLE, and the counters and synchronizers SHALL be cleared.
REQ-028 Reset asserted mid-transaction SHALL abort it with no `mem_wr`; after release the block SHALL wait for a new `cs_n` falling edge.

Configuration
REQ-029 Macro SPI_MEM_AUTOINC_EN, when defined: after each data byte (write strobe, or read load), `mem_addr` SHALL increment by 1 and wrap from 2^ADDR_W-1 to 0, allowing burst transfers.
REQ-030 When SPI_MEM_AUTOINC_EN is undefined, `mem_addr` SHALL stay at the command address for the whole transaction; repeated bytes SHALL rewrite or reread the same location.

Structure
REQ-031 Package spi_mem_pkg SHALL hold the FSM state enum, CMD_WR_BIT (7), and the default ADDR_W and DATA_W.
REQ-032 Sub-module spi_mem_sync SHALL implement the 2-flop synchronizer plus rise/fall edge detect for `sclk`, and the 2-flop synchronizer for `cs_n` and `mosi`.

Verification
REQ-033 Reset check: assert `rst_n` low mid-byte -> all outputs 0 and no `mem_wr`; after release, a fresh transaction succeeds.
REQ-034 Single write: send 0x85 then 0x3C -> one `mem_wr` pulse with `mem_addr`=0x05 and `mem_wdata`=0x3C.
REQ-035 Read: model memory holds 0xA7 at 0x05; send 0x05 then 8 dummy clocks -> `miso` bits 1,0,1,0,0,1,1,1 sampled on rising edges.
REQ-036 Burst wrap with SPI_MEM_AUTOINC_EN: send 0xFF then 0x11, 0x22 -> writes 0x11@0x7F and 0x22@0x00; without the macro -> both writes at 0x7F.
REQ-037 Abort: send 0x80 then 5 data bits, then raise `cs_n` -> no `mem_wr`, and `active` falls within 3 `clk`.
REQ-038 Minimum-timing stress: `sclk` phases of exactly 4 `clk`, 16-byte burst read -> every byte matches the memory model.

Source files
------------

// File: rtl/spi_mem_pkg.sv
// Shared types and defaults for the SPI memory loader.
package spi_mem_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CMD  = 2'd1,
    DATA = 2'd2
  } state_t;

  localparam int CMD_WR_BIT = 7;
  localparam int DEF_ADDR_W = 7;
  localparam int DEF_DATA_W = 8;

endpackage

// File: rtl/spi_mem_sync.sv
// Brings sclk, cs_n and mosi into the clk domain and flags sclk edges.
module spi_mem_sync (
  input  logic clk,
  input  logic rst_n,
  input  logic sclk,
  input  logic cs_n,
  input  logic mosi,
  output logic sclk_rise,
  output logic sclk_fall,
  output logic cs_n_sync,
  output logic mosi_sync
);

  logic [2:0] sclk_sync_reg;
  logic [1:0] cs_sync_reg;
  logic [1:0] mosi_sync_reg;

  // Cleared to 0: a cs_n held low through reset never looks like a new falling edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sclk_sync_reg <= '0;
      cs_sync_reg   <= '0;
      mosi_sync_reg <= '0;
    end else begin
      sclk_sync_reg <= {sclk_sync_reg[1:0], sclk};
      cs_sync_reg   <= {cs_sync_reg[0], cs_n};
      mosi_sync_reg <= {mosi_sync_reg[0], mosi};
    end
  end

  assign sclk_rise = sclk_sync_reg[1] & ~sclk_sync_reg[2];
  assign sclk_fall = ~sclk_sync_reg[1] & sclk_sync_reg[2];
  assign cs_n_sync = cs_sync_reg[1];
  assign mosi_sync = mosi_sync_reg[1];

endmodule

// File: rtl/spi_mem_loader.sv
// SPI (mode 0) slave giving byte-wide read/write access to a synchronous memory.
// Define SPI_MEM_AUTOINC_EN to step mem_addr after every data byte (burst mode).
module spi_mem_loader
  import spi_mem_pkg::*;
#(
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int DATA_W = DEF_DATA_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              sclk,
  input  logic              cs_n,
  input  logic              mosi,
  output logic              miso,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              mem_wr,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              active
);

  localparam int CNT_W = $clog2(DATA_W);
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_W - 1);

  logic sclk_rise, sclk_fall, cs_n_s, mosi_s;

  spi_mem_sync u_sync (
    .clk       (clk),
    .rst_n     (rst_n),
    .sclk      (sclk),
    .cs_n      (cs_n),
    .mosi      (mosi),
    .sclk_rise (sclk_rise),
    .sclk_fall (sclk_fall),
    .cs_n_sync (cs_n_s),
    .mosi_sync (mosi_s)
  );

  state_t            state_reg;
  logic [CNT_W-1:0]  bit_cnt_reg;
  logic [DATA_W-1:0] rx_reg;
  logic [DATA_W-1:0] tx_reg;
  logic [1:0]        ld_pipe_reg;
  logic              wr_dir_reg;
  logic              cs_prev_reg;

  logic [DATA_W-1:0] rx_next;
  logic              byte_done;
  logic              cs_fall;

  assign rx_next   = {rx_reg[DATA_W-2:0], mosi_s};
  assign byte_done = sclk_rise && (bit_cnt_reg == LAST_BIT);
  assign cs_fall   = cs_prev_reg & ~cs_n_s;
  assign miso      = tx_reg[DATA_W-1];
  assign active    = (state_reg != IDLE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg   <= IDLE;
      bit_cnt_reg <= '0;
      rx_reg      <= '0;
      tx_reg      <= '0;
      ld_pipe_reg <= '0;
      wr_dir_reg  <= 1'b0;
      cs_prev_reg <= 1'b0;
      mem_addr    <= '0;
      mem_wdata   <= '0;
      mem_wr      <= 1'b0;
    end else begin
      cs_prev_reg <= cs_n_s;
      mem_wr      <= 1'b0;
      ld_pipe_reg <= {ld_pipe_reg[0], 1'b0};
      // Read data is captured two clk after the address settles (registered memory read).
      if (ld_pipe_reg[1])
        tx_reg <= mem_rdata;
`ifdef SPI_MEM_AUTOINC_EN
      if (mem_wr || ld_pipe_reg[1])
        mem_addr <= mem_addr + ADDR_W'(1);
`endif
      case (state_reg)
        IDLE: begin
          if (cs_fall) begin
            state_reg   <= CMD;
            bit_cnt_reg <= '0;
            rx_reg      <= '0;
            tx_reg      <= '0;
          end
        end
        CMD, DATA: begin
          if (cs_n_s) begin
            state_reg   <= IDLE;
            bit_cnt_reg <= '0;
            ld_pipe_reg <= '0;
            tx_reg      <= '0;
          end else begin
            // bit_cnt is 0 only on the first falling edge after a byte, which must not shift.
            if (sclk_fall && (bit_cnt_reg != '0) && (state_reg == DATA) && !wr_dir_reg)
              tx_reg <= {tx_reg[DATA_W-2:0], 1'b0};
            if (sclk_rise) begin
              rx_reg      <= rx_next;
              bit_cnt_reg <= byte_done ? '0 : bit_cnt_reg + CNT_W'(1);
            end
            if (byte_done) begin
              if (state_reg == CMD) begin
                state_reg  <= DATA;
                mem_addr   <= rx_next[ADDR_W-1:0];
                wr_dir_reg <= rx_next[CMD_WR_BIT];
                if (!rx_next[CMD_WR_BIT])
                  ld_pipe_reg <= 2'b01;
              end else if (wr_dir_reg) begin
                mem_wdata <= rx_next;
                mem_wr    <= 1'b1;
              end else begin
                ld_pipe_reg <= 2'b01;
              end
            end
          end
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_spi_mem_loader.sv
// Scoreboard bench for spi_mem_loader; stimulus queues expectations, monitors pop and compare.
module tb_spi_mem_loader;

  logic       clk;
  logic       rst_n;
  logic       sclk;
  logic       cs_n;
  logic       mosi;
  logic       miso;
  logic [6:0] mem_addr;
  logic [7:0] mem_wdata;
  logic       mem_wr;
  logic [7:0] mem_rdata;
  logic       active;

  spi_mem_loader #(.ADDR_W(7), .DATA_W(8)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .sclk      (sclk),
    .cs_n      (cs_n),
    .mosi      (mosi),
    .miso      (miso),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_wr    (mem_wr),
    .mem_rdata (mem_rdata),
    .active    (active)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [7:0] sim_mem [128];
  logic [7:0] ref_mem [128];

  always @(posedge clk) begin
    mem_rdata <= sim_mem[mem_addr];
    if (mem_wr) sim_mem[mem_addr] <= mem_wdata;
  end

  logic [14:0] wr_q[$];
  logic [7:0]  rd_q[$];
  int          checks = 0;
  int          errors = 0;
  int          half   = 5;
  logic        rd_mon = 1'b0;
  logic        wr_mon = 1'b0;

  function automatic logic [6:0] next_addr(input logic [6:0] a);
`ifdef SPI_MEM_AUTOINC_EN
    return a + 7'd1;
`else
    return a;
`endif
  endfunction

  task automatic clk_wait(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  task automatic spi_byte(input logic [7:0] b, input int nbits, input bit early_cs);
    for (int i = 7; i >= 8 - nbits; i--) begin
      mosi = b[i];
      clk_wait(half);
      sclk = 1'b1;
      if (early_cs && i == 0) begin
        clk_wait(1);
        cs_n = 1'b1;
      end
      clk_wait(half);
      sclk = 1'b0;
    end
  endtask

  task automatic write_txn(input logic [6:0] a, input logic [7:0] d0, input logic [7:0] d1,
                           input int n, input bit early);
    logic [6:0] ea;
    logic [7:0] d;
    ea = a;
    cs_n = 1'b0;
    clk_wait(half);
    spi_byte({1'b1, a}, 8, 1'b0);
    wr_mon = 1'b1;
    for (int k = 0; k < n; k++) begin
      d = (k == 0) ? d0 : d1;
      wr_q.push_back({ea, d});
      ref_mem[ea] = d;
      ea = next_addr(ea);
      spi_byte(d, 8, early && (k == n - 1));
    end
    wr_mon = 1'b0;
    clk_wait(half);
    cs_n = 1'b1;
    clk_wait(8);
  endtask

  task automatic read_txn(input logic [6:0] a, input int n);
    logic [6:0] ea;
    ea = a;
    cs_n = 1'b0;
    clk_wait(half);
    spi_byte({1'b0, a}, 8, 1'b0);
    rd_mon = 1'b1;
    for (int k = 0; k < n; k++) begin
      rd_q.push_back(ref_mem[ea]);
      ea = next_addr(ea);
      spi_byte(8'h00, 8, 1'b0);
    end
    rd_mon = 1'b0;
    clk_wait(half);
    cs_n = 1'b1;
    clk_wait(8);
  endtask

  task automatic check_outputs_zero(input string name);
    checks++;
    if ({mem_addr, mem_wdata, mem_wr, miso, active} !== 18'd0) begin
      errors++;
      $display("FAIL %s: addr=%h wdata=%h wr=%b miso=%b active=%b required all 0",
               name, mem_addr, mem_wdata, mem_wr, miso, active);
    end
  endtask

  task automatic check_active(input string name, input logic exp);
    checks++;
    if (active !== exp) begin
      errors++;
      $display("FAIL %s: active=%b required %b", name, active, exp);
    end
  endtask

  // Write monitor: every mem_wr cycle must match the next expected write.
  initial begin
    logic [14:0] e;
    forever begin
      @(negedge clk);
      if (mem_wr === 1'b1) begin
        checks++;
        if (wr_q.size() == 0) begin
          errors++;
          $display("FAIL wr_unexpected: addr=%h data=%h required no write", mem_addr, mem_wdata);
        end else begin
          e = wr_q.pop_front();
          if ({mem_addr, mem_wdata} !== e) begin
            errors++;
            $display("FAIL wr_data: addr=%h data=%h required addr=%h data=%h",
                     mem_addr, mem_wdata, e[14:8], e[7:0]);
          end else begin
            $display("write addr=%h data=%h ok", mem_addr, mem_wdata);
          end
        end
      end
    end
  end

  // SPI monitor: assembles miso bytes on sclk rising edges in read phases.
  initial begin
    int         rcnt;
    logic [7:0] rbyte;
    logic [7:0] e;
    rcnt  = 0;
    rbyte = 8'h00;
    forever begin
      @(posedge sclk);
      if (wr_mon) begin
        checks++;
        if (miso !== 1'b0) begin
          errors++;
          $display("FAIL miso_in_write: miso=%b required 0", miso);
        end
      end
      if (!rd_mon) begin
        rcnt = 0;
      end else begin
        rbyte = {rbyte[6:0], miso};
        rcnt++;
        if (rcnt == 8) begin
          rcnt = 0;
          checks++;
          if (rd_q.size() == 0) begin
            errors++;
            $display("FAIL rd_unexpected: byte=%h required none", rbyte);
          end else begin
            e = rd_q.pop_front();
            if (rbyte !== e) begin
              errors++;
              $display("FAIL rd_byte: got=%h required %h", rbyte, e);
            end else begin
              $display("read byte=%h ok", rbyte);
            end
          end
        end
      end
    end
  end

  initial begin
    rst_n = 1'b0;
    cs_n  = 1'b1;
    sclk  = 1'b0;
    mosi  = 1'b0;
    for (int i = 0; i < 128; i++) begin
      sim_mem[i] = 8'(i * 3 + 1);
      ref_mem[i] = 8'(i * 3 + 1);
    end
    sim_mem[5] = 8'hA7;
    ref_mem[5] = 8'hA7;

    clk_wait(3);
    check_outputs_zero("reset_idle");
    rst_n = 1'b1;
    clk_wait(5);

    // Reset in the middle of a write data byte.
    cs_n = 1'b0;
    clk_wait(half);
    spi_byte(8'h85, 8, 1'b0);
    spi_byte(8'hFF, 4, 1'b0);
    check_active("active_before_reset", 1'b1);
    rst_n = 1'b0;
    clk_wait(1);
    check_outputs_zero("reset_midbyte");
    rst_n = 1'b1;
    clk_wait(6);
    check_active("no_restart_without_cs_fall", 1'b0);
    cs_n = 1'b1;
    clk_wait(6);

    read_txn(7'h05, 1);                                // expects 0xA7
    write_txn(7'h05, 8'h3C, 8'h00, 1, 1'b1);           // cs_n raised right at byte boundary
    read_txn(7'h05, 1);                                // expects 0x3C
    write_txn(7'h7F, 8'h11, 8'h22, 2, 1'b0);           // burst across the wrap

    // Abort: write command then 5 data bits.
    cs_n = 1'b0;
    clk_wait(half);
    spi_byte(8'h80, 8, 1'b0);
    spi_byte(8'hFF, 5, 1'b0);
    check_active("active_in_abort", 1'b1);
    cs_n = 1'b1;
    clk_wait(3);
    check_active("abort_idle_3clk", 1'b0);
    clk_wait(8);

    half = 4;
    read_txn(7'h78, 16);
    half = 5;

    clk_wait(20);
    checks++;
    if (wr_q.size() != 0) begin
      errors++;
      $display("FAIL wr_missing: pending=%0d required 0", wr_q.size());
    end
    checks++;
    if (rd_q.size() != 0) begin
      errors++;
      $display("FAIL rd_missing: pending=%0d required 0", rd_q.size());
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
